// File: rtl/t48_psw_stack_pkg.sv
// t48_pack: constants and types shared by the T48 PSW/stack slice.
//   PSW bit positions, the idle value of the read mux, and the stack
//   entry layout {psw[3:0], pc}. The top builds its own entry type from
//   the same fields so that PC_W can be changed per instance.
package t48_pack;

  localparam int PSW_W  = 4;
  localparam int CY_BIT = 3;
  localparam int AC_BIT = 2;
  localparam int F0_BIT = 1;
  localparam int BS_BIT = 0;

  localparam logic [3:0] RD_IDLE = 4'hF;

  typedef logic [PSW_W-1:0] psw_t;

  // Entry layout at the default 12-bit program counter width.
  localparam int PC_W_DEF = 12;
  typedef struct packed {
    psw_t                psw;
    logic [PC_W_DEF-1:0] pc;
  } stack_entry_t;

endpackage

// File: rtl/t48_psw_stack_if.sv
// t48_psw_stack_if: decoder/ALU side bus of the PSW/stack block.
//   master : decoder/ALU (drives controls, data_i, pc_i)
//   slave  : t48_psw_stack (drives data_o, flags, pc_o, pop_valid_o,
//            sp_o, overflow_o, underflow_o)
interface t48_psw_stack_if #(
  parameter int SP_W = 3,
  parameter int PC_W = 12
);
  logic            en_clk_i;
  logic [7:0]      data_i;
  logic            read_psw_i;
  logic            read_sp_i;
  logic            write_psw_i;
  logic            write_sp_i;
  logic            special_data_i;
  logic            write_carry_i;
  logic            write_aux_carry_i;
  logic            write_f0_i;
  logic            write_bs_i;
  logic            aux_carry_i;
  logic            push_i;
  logic [PC_W-1:0] pc_i;
  logic            pop_i;
  logic            restore_psw_i;

  logic [7:0]      data_o;
  logic            carry_o;
  logic            aux_carry_o;
  logic            f0_o;
  logic            bs_o;
  logic [PC_W-1:0] pc_o;
  logic            pop_valid_o;
  logic [SP_W-1:0] sp_o;
  logic            overflow_o;
  logic            underflow_o;

  modport master (
    output en_clk_i, data_i, read_psw_i, read_sp_i, write_psw_i, write_sp_i,
           special_data_i, write_carry_i, write_aux_carry_i, write_f0_i,
           write_bs_i, aux_carry_i, push_i, pc_i, pop_i, restore_psw_i,
    input  data_o, carry_o, aux_carry_o, f0_o, bs_o, pc_o, pop_valid_o,
           sp_o, overflow_o, underflow_o
  );

  modport slave (
    input  en_clk_i, data_i, read_psw_i, read_sp_i, write_psw_i, write_sp_i,
           special_data_i, write_carry_i, write_aux_carry_i, write_f0_i,
           write_bs_i, aux_carry_i, push_i, pc_i, pop_i, restore_psw_i,
    output data_o, carry_o, aux_carry_o, f0_o, bs_o, pc_o, pop_valid_o,
           sp_o, overflow_o, underflow_o
  );
endinterface

// File: rtl/t48_psw_stack_ram.sv
// t48_stack_ram: 2**AW x DW register array for the on-chip stack.
//   clk_i, res_i : clock, synchronous active-high clear of all entries
//   we_i, waddr_i, wdata_i : single write port
//   raddr_i, rdata_o       : single asynchronous read port
module t48_stack_ram #(
  parameter int AW = 3,
  parameter int DW = 16
) (
  input  logic          clk_i,
  input  logic          res_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  localparam int DEPTH = 2**AW;

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (res_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/t48_psw_stack.sv
// t48_psw_stack: PSW flags, stack pointer and on-chip return stack.
//   clk_i : clock, res_i : synchronous active-high reset
//   bus   : slave side of t48_psw_stack_if (controls, data bus, read mux,
//           flag outputs, registered pop return address, SP, error flags)
// WRAP_MODE=1 lets SP wrap like the 8048; WRAP_MODE=0 rejects pushes on a
// full stack and pops on an empty one (error flag still set).
module t48_psw_stack
  import t48_pack::*;
#(
  parameter int SP_W      = 3,
  parameter int PC_W      = 12,
  parameter int WRAP_MODE = 1
) (
  input  logic            clk_i,
  input  logic            res_i,
  t48_psw_stack_if.slave  bus
);
  localparam int DEPTH = 2**SP_W;
  localparam int EW    = PSW_W + PC_W;
  localparam logic [SP_W:0] CNT_FULL = (SP_W+1)'(DEPTH);
  localparam logic [SP_W:0] CNT_ONE  = (SP_W+1)'(1);

  typedef struct packed {
    psw_t            psw;
    logic [PC_W-1:0] pc;
  } entry_t;

  psw_t            psw_q, psw_d;
  logic [SP_W-1:0] sp_q, sp_d, sp_dec, sp_inc;
  logic [SP_W:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d, unf_q, unf_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            pv_q, pv_d;
  logic            empty, full, pop_ok, push_ok, ram_we;
  entry_t          wr_entry, rd_entry;
  logic [EW-1:0]   rd_raw;

  always_comb begin
    sp_dec  = sp_q - SP_W'(1);
    sp_inc  = sp_q + SP_W'(1);
    empty   = (cnt_q == '0);
    full    = (cnt_q == CNT_FULL);
    pop_ok  = bus.pop_i && (!empty || (WRAP_MODE != 0));
    // pop has priority, so a simultaneous push is dropped entirely
    push_ok = bus.push_i && !bus.pop_i && (!full || (WRAP_MODE != 0));
  end

  // pushed entry carries the PSW as it was before this edge
  assign wr_entry = '{psw: psw_q, pc: bus.pc_i};
  assign ram_we   = bus.en_clk_i && push_ok;
  assign rd_entry = entry_t'(rd_raw);

  t48_stack_ram #(.AW(SP_W), .DW(EW)) u_ram (
    .clk_i   (clk_i),
    .res_i   (res_i),
    .we_i    (ram_we),
    .waddr_i (sp_q),
    .wdata_i (wr_entry),
    .raddr_i (sp_dec),
    .rdata_o (rd_raw)
  );

  always_comb begin
    sp_d  = sp_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    pc_d  = pc_q;
    pv_d  = 1'b0;
    if (bus.pop_i) begin
      if (empty) unf_d = 1'b1;
      if (pop_ok) begin
        sp_d = sp_dec;
        if (!empty) cnt_d = cnt_q - CNT_ONE;
        pc_d = rd_entry.pc;
        pv_d = 1'b1;
      end
    end else if (bus.push_i) begin
      if (full) ovf_d = 1'b1;
      if (push_ok) begin
        sp_d = sp_inc;
        if (!full) cnt_d = cnt_q + CNT_ONE;
      end
    end else if (bus.write_sp_i) begin
      sp_d  = bus.data_i[SP_W-1:0];
      cnt_d = {1'b0, bus.data_i[SP_W-1:0]};
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
  end

  // later assignments win: restore < full PSW write < single-bit writes
  always_comb begin
    psw_d = psw_q;
    if (pop_ok && bus.restore_psw_i) psw_d = rd_entry.psw;
    if (bus.write_psw_i)             psw_d = bus.data_i[7:4];
    if (bus.write_carry_i)           psw_d[CY_BIT] = bus.special_data_i;
    if (bus.write_aux_carry_i)       psw_d[AC_BIT] = bus.aux_carry_i;
    if (bus.write_f0_i)              psw_d[F0_BIT] = bus.special_data_i;
    if (bus.write_bs_i)              psw_d[BS_BIT] = bus.special_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (res_i) begin
      psw_q <= '0;
      sp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      pc_q  <= '0;
      pv_q  <= 1'b0;
    end else begin
      // the valid pulse always drops after one cycle, even when gated
      pv_q <= bus.en_clk_i ? pv_d : 1'b0;
      if (bus.en_clk_i) begin
        psw_q <= psw_d;
        sp_q  <= sp_d;
        cnt_q <= cnt_d;
        ovf_q <= ovf_d;
        unf_q <= unf_d;
        pc_q  <= pc_d;
      end
    end
  end

  assign bus.data_o[7:4] = bus.read_psw_i ? psw_q : RD_IDLE;
  assign bus.data_o[3:0] = bus.read_sp_i ? (4'b1000 | 4'(sp_q)) : RD_IDLE;
  assign bus.carry_o     = psw_q[CY_BIT];
  assign bus.aux_carry_o = psw_q[AC_BIT];
  assign bus.f0_o        = psw_q[F0_BIT];
  assign bus.bs_o        = psw_q[BS_BIT];
  assign bus.pc_o        = pc_q;
  assign bus.pop_valid_o = pv_q;
  assign bus.sp_o        = sp_q;
  assign bus.overflow_o  = ovf_q;
  assign bus.underflow_o = unf_q;

  // only the SP field of the low nibble is consumed
  logic unused_data;
  assign unused_data = ^bus.data_i;
endmodule

// File: tb/tb_t48_psw_stack.sv
// Testbench for t48_psw_stack: one wrapping instance (a) and one
// saturating instance (b); expected pops are queued by the stimulus and
// checked by a monitor whenever pop_valid_o is seen.
module tb_t48_psw_stack;
  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        res, en_clk, rd_psw, rd_sp, wr_psw, wr_sp, special;
    logic        wr_cy, wr_ac, wr_f0, wr_bs, aux, push, pop, restore;
    logic [7:0]  data;
    logic [11:0] pc;
  } ctrl_t;

  typedef struct {
    logic [11:0] pc;
    logic [3:0]  psw;
  } exp_t;

  ctrl_t ca, cb;
  exp_t  qa[$], qb[$];
  int    total = 0;
  int    bad   = 0;

  t48_psw_stack_if #(.SP_W(3), .PC_W(12)) ifa ();
  t48_psw_stack_if #(.SP_W(3), .PC_W(12)) ifb ();

  t48_psw_stack #(.SP_W(3), .PC_W(12), .WRAP_MODE(1)) dut_a (
    .clk_i (clk_i), .res_i (ca.res), .bus (ifa.slave));
  t48_psw_stack #(.SP_W(3), .PC_W(12), .WRAP_MODE(0)) dut_b (
    .clk_i (clk_i), .res_i (cb.res), .bus (ifb.slave));

  always_comb begin
    ifa.en_clk_i = ca.en_clk;   ifb.en_clk_i = cb.en_clk;
    ifa.data_i = ca.data;       ifb.data_i = cb.data;
    ifa.read_psw_i = ca.rd_psw; ifb.read_psw_i = cb.rd_psw;
    ifa.read_sp_i = ca.rd_sp;   ifb.read_sp_i = cb.rd_sp;
    ifa.write_psw_i = ca.wr_psw; ifb.write_psw_i = cb.wr_psw;
    ifa.write_sp_i = ca.wr_sp;  ifb.write_sp_i = cb.wr_sp;
    ifa.special_data_i = ca.special; ifb.special_data_i = cb.special;
    ifa.write_carry_i = ca.wr_cy; ifb.write_carry_i = cb.wr_cy;
    ifa.write_aux_carry_i = ca.wr_ac; ifb.write_aux_carry_i = cb.wr_ac;
    ifa.write_f0_i = ca.wr_f0;  ifb.write_f0_i = cb.wr_f0;
    ifa.write_bs_i = ca.wr_bs;  ifb.write_bs_i = cb.wr_bs;
    ifa.aux_carry_i = ca.aux;   ifb.aux_carry_i = cb.aux;
    ifa.push_i = ca.push;       ifb.push_i = cb.push;
    ifa.pc_i = ca.pc;           ifb.pc_i = cb.pc;
    ifa.pop_i = ca.pop;         ifb.pop_i = cb.pop;
    ifa.restore_psw_i = ca.restore; ifb.restore_psw_i = cb.restore;
  end

  function automatic ctrl_t idle();
    ctrl_t c;
    c = '{res: 1'b0, en_clk: 1'b1, rd_psw: 1'b0, rd_sp: 1'b0, wr_psw: 1'b0,
          wr_sp: 1'b0, special: 1'b0, wr_cy: 1'b0, wr_ac: 1'b0, wr_f0: 1'b0,
          wr_bs: 1'b0, aux: 1'b0, push: 1'b0, pop: 1'b0, restore: 1'b0,
          data: 8'h00, pc: 12'h000};
    return c;
  endfunction

  function automatic ctrl_t c_push(input logic [11:0] pc);
    ctrl_t c = idle();
    c.push = 1'b1; c.pc = pc;
    return c;
  endfunction

  function automatic ctrl_t c_pop(input logic restore);
    ctrl_t c = idle();
    c.pop = 1'b1; c.restore = restore;
    return c;
  endfunction

  function automatic ctrl_t c_wpsw(input logic [7:0] d);
    ctrl_t c = idle();
    c.wr_psw = 1'b1; c.data = d;
    return c;
  endfunction

  function automatic ctrl_t c_wsp(input logic [7:0] d);
    ctrl_t c = idle();
    c.wr_sp = 1'b1; c.data = d;
    return c;
  endfunction

  function automatic ctrl_t c_res();
    ctrl_t c = idle();
    c.res = 1'b1;
    return c;
  endfunction

  task automatic step(input bit sel_b, input ctrl_t c);
    if (sel_b) cb = c; else ca = c;
    @(posedge clk_i); #1;
    ca = idle(); cb = idle();
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] flags_a();
    return {ifa.carry_o, ifa.aux_carry_o, ifa.f0_o, ifa.bs_o};
  endfunction

  function automatic logic [3:0] flags_b();
    return {ifb.carry_o, ifb.aux_carry_o, ifb.f0_o, ifb.bs_o};
  endfunction

  always @(negedge clk_i) begin
    exp_t e;
    if (ifa.pop_valid_o === 1'b1) begin
      if (qa.size() == 0) begin
        total++; bad++;
        $display("FAIL a_unexpected_pop: got pc %0h expected no pop", ifa.pc_o);
      end else begin
        e = qa.pop_front();
        chk("a_pop_pc", 32'(ifa.pc_o), 32'(e.pc));
        chk("a_pop_psw", 32'(flags_a()), 32'(e.psw));
      end
    end
    if (ifb.pop_valid_o === 1'b1) begin
      if (qb.size() == 0) begin
        total++; bad++;
        $display("FAIL b_unexpected_pop: got pc %0h expected no pop", ifb.pc_o);
      end else begin
        e = qb.pop_front();
        chk("b_pop_pc", 32'(ifb.pc_o), 32'(e.pc));
        chk("b_pop_psw", 32'(flags_b()), 32'(e.psw));
      end
    end
  end

  initial begin
    ctrl_t c;
    ca = c_res(); cb = c_res();
    @(posedge clk_i); #1;
    ca = idle(); cb = idle();

    // reset state
    chk("rst_sp", 32'(ifa.sp_o), 0);
    chk("rst_flags", 32'(flags_a()), 0);
    chk("rst_pc", 32'(ifa.pc_o), 0);
    chk("rst_pv", 32'(ifa.pop_valid_o), 0);
    chk("rst_err", 32'({ifa.overflow_o, ifa.underflow_o}), 0);
    chk("rst_data_idle", 32'(ifa.data_o), 32'hFF);

    // PSW load and read mux
    step(0, c_wpsw(8'hA5));
    chk("wpsw_flags", 32'(flags_a()), 32'hA);
    ca.rd_psw = 1'b1; ca.rd_sp = 1'b1; #1;
    chk("read_mux", 32'(ifa.data_o), 32'hA8);
    ca = idle(); #1;

    // push, overwrite PSW, pop with restore
    c = idle(); c.wr_cy = 1'b1; c.special = 1'b1;
    step(0, c);
    step(0, c_push(12'h123));
    chk("push_sp", 32'(ifa.sp_o), 1);
    step(0, c_wpsw(8'h00));
    chk("psw_cleared", 32'(flags_a()), 0);
    qa.push_back('{pc: 12'h123, psw: 4'hA});
    step(0, c_pop(1'b1));
    chk("retr_carry", 32'(ifa.carry_o), 1);
    chk("retr_sp", 32'(ifa.sp_o), 0);
    step(0, idle());
    chk("pv_one_cycle", 32'(ifa.pop_valid_o), 0);

    // wrap mode: 9 pushes overwrite entry 0
    for (int i = 0; i < 9; i++) step(0, c_push(12'(i)));
    chk("wrap_ovf", 32'(ifa.overflow_o), 1);
    chk("wrap_sp", 32'(ifa.sp_o), 1);
    qa.push_back('{pc: 12'h008, psw: 4'hA});
    step(0, c_pop(1'b0));
    chk("wrap_pop_sp", 32'(ifa.sp_o), 0);

    // push+pop together: pop wins, entry not written
    step(0, c_res());
    step(0, c_push(12'h011));
    step(0, c_push(12'h022));
    c = c_push(12'h077); c.pop = 1'b1;
    qa.push_back('{pc: 12'h022, psw: 4'h0});
    step(0, c);
    chk("pushpop_sp", 32'(ifa.sp_o), 1);
    step(0, c_wsp(8'h03));
    chk("wsp_sp", 32'(ifa.sp_o), 3);
    qa.push_back('{pc: 12'h000, psw: 4'h0});
    step(0, c_pop(1'b0));
    qa.push_back('{pc: 12'h022, psw: 4'h0});
    step(0, c_pop(1'b0));
    chk("pushpop_sp2", 32'(ifa.sp_o), 1);

    // single-bit write beats full PSW write
    c = c_wpsw(8'h00); c.wr_cy = 1'b1; c.special = 1'b1;
    step(0, c);
    chk("cy_over_wpsw", 32'(flags_a()), 32'h8);

    // clock qualifier low: push ignored
    c = c_push(12'h055); c.en_clk = 1'b0;
    step(0, c);
    chk("gated_sp", 32'(ifa.sp_o), 1);
    chk("gated_flags", 32'({flags_a(), ifa.overflow_o, ifa.underflow_o}), 32'h20);

    // reset right after a pop, then reset coincident with a pop
    qa.push_back('{pc: 12'h011, psw: 4'h8});
    step(0, c_pop(1'b0));
    step(0, c_res());
    chk("res_after_pop_pv", 32'(ifa.pop_valid_o), 0);
    chk("res_after_pop_out", 32'({ifa.pc_o, flags_a(), ifa.sp_o}), 0);
    c = c_pop(1'b1); c.res = 1'b1;
    step(0, c);
    chk("res_with_pop", 32'({ifa.pop_valid_o, ifa.underflow_o, ifa.sp_o}), 0);

    // saturate mode: rejected pop on empty
    step(1, c_wpsw(8'h50));
    step(1, c_pop(1'b1));
    chk("sat_unf", 32'(ifb.underflow_o), 1);
    chk("sat_unf_sp", 32'(ifb.sp_o), 0);
    chk("sat_unf_pv", 32'(ifb.pop_valid_o), 0);
    chk("sat_unf_psw", 32'(flags_b()), 32'h5);
    step(1, c_wsp(8'h03));
    chk("sat_wsp_sp", 32'(ifb.sp_o), 3);
    chk("sat_wsp_unf", 32'(ifb.underflow_o), 0);

    // saturate mode: fill, then rejected push
    for (int i = 1; i <= 5; i++) step(1, c_push(12'(i)));
    chk("sat_full_sp", 32'(ifb.sp_o), 0);
    chk("sat_full_ovf", 32'(ifb.overflow_o), 0);
    step(1, c_push(12'h066));
    chk("sat_ovf", 32'(ifb.overflow_o), 1);
    chk("sat_ovf_sp", 32'(ifb.sp_o), 0);
    qb.push_back('{pc: 12'h005, psw: 4'h5});
    step(1, c_pop(1'b0));
    chk("sat_pop_sp", 32'(ifb.sp_o), 7);

    repeat (3) @(posedge clk_i);
    #1;
    chk("a_queue_drained", 32'(qa.size()), 0);
    chk("b_queue_drained", 32'(qb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
